// File: rtl/spi_pkg.sv
// Shared SPI definitions for the spi_master / spi_slave pair.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  // Mode 0: sclk idles low, data sampled on rising edge, changed on falling edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall pulse outputs.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise =  sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled sclk/cs/mosi, MSB-first shift in/out, word-wrapping frames.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d(cs), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi gets the same depth so it lines up with the synchronized sclk edge.
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  spi_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  reload_pend;
  logic                  last_bit;

  assign rx_next  = {rx_sr[DATA_WIDTH-2:0], mosi_s};
  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      miso        <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (cs_fall) begin
          tx_sr       <= tx_data;
          miso        <= tx_data[DATA_WIDTH-1];
          bit_cnt     <= '0;
          reload_pend <= 1'b0;
        end
      end else if (cs_rise) begin
        // Deselect beats any coincident sclk edge; a partial word is dropped.
        miso        <= 1'b0;
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
      end else if (sclk_rise) begin
        rx_sr <= rx_next;
        if (last_bit) begin
          rx_data     <= rx_next;
          rx_valid    <= 1'b1;
          bit_cnt     <= '0;
          reload_pend <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (sclk_fall) begin
        if (reload_pend) begin
          tx_sr       <= tx_data;
          miso        <= tx_data[DATA_WIDTH-1];
          reload_pend <= 1'b0;
        end else begin
          tx_sr <= tx_sr << 1;
          miso  <= tx_sr[DATA_WIDTH-2];
        end
      end
    end
  end

  assign busy = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single frames plus hand-written multi-cycle sequences.
module tb_spi_slave;

  localparam int HALF = 6;

  logic       clk = 1'b0, clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic       sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic       miso, rx_valid, busy;
  logic [7:0] tx_data = 8'h00, rx_data;

  int total = 0, bad = 0;
  int vld_hi = 0, vld_pulses = 0;
  logic vld_prev = 1'b0;
  logic [7:0] rx_q[$];

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 if (clk_en) clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      vld_hi++;
      rx_q.push_back(rx_data);
    end
    if (rx_valid && !vld_prev) vld_pulses++;
    vld_prev = rx_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One mode-0 bit: drive mosi with sclk low, sample miso at the rising edge.
  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    cyc(HALF);
    sclk = 1'b1;
    m = miso;
    cyc(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_word(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) spi_bit(mo[i], mi[i]);
  endtask

  task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
    cs = 1'b0;
    cyc(HALF);
    spi_word(mo, mi);
    cyc(HALF);
    cs = 1'b1;
    cyc(10);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] mi, mi2;
    logic       b;
    int         v0;

    vecs[0] = '{8'h3C, 8'hAA, 8'hAA, 8'h3C};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[2] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{8'hA5, 8'h5A, 8'h5A, 8'hA5};
    vecs[4] = '{8'h01, 8'h80, 8'h80, 8'h01};

    // Reset with no clock running: outputs must clear asynchronously.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_miso", miso, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    clk_en = 1'b1;
    cyc(5);
    @(negedge clk) rst_n = 1'b1;
    cyc(10);

    // Abort after 4 bits of 0xF0, then a full 0x12 frame.
    v0 = vld_hi;
    tx_data = 8'hA5;
    cs = 1'b0;
    cyc(HALF);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    cyc(HALF);
    chk("abort_busy_mid", busy, 1);
    cs = 1'b1;
    cyc(10);
    chk("abort_no_valid", vld_hi - v0, 0);
    chk("abort_rx_data", rx_data, 8'h00);
    chk("abort_busy", busy, 0);
    chk("abort_miso", miso, 0);
    v0 = vld_hi;
    frame(8'h12, mi);
    chk("after_abort_rx", rx_data, 8'h12);
    chk("after_abort_vld", vld_hi - v0, 1);

    // Table of single frames.
    foreach (vecs[k]) begin
      v0 = vld_hi;
      tx_data = vecs[k].tx;
      cyc(2);
      frame(vecs[k].mo, mi);
      chk($sformatf("tbl%0d_rx", k), rx_data, vecs[k].exp_rx);
      chk($sformatf("tbl%0d_miso", k), mi, vecs[k].exp_miso);
      chk($sformatf("tbl%0d_vld", k), vld_hi - v0, 1);
      chk($sformatf("tbl%0d_busy", k), busy, 0);
      chk($sformatf("tbl%0d_miso_idle", k), miso, 0);
    end
    chk("pulse_width", vld_hi, vld_pulses);

    // Back-to-back: two words in one frame, response word swapped after the first rx_valid.
    rx_q.delete();
    v0 = vld_hi;
    tx_data = 8'h81;
    cyc(2);
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (rx_valid) begin
            tx_data = 8'h7E;
            break;
          end
        end
      end
    join_none
    cs = 1'b0;
    cyc(HALF);
    spi_word(8'h5A, mi);
    chk("b2b_busy_mid", busy, 1);
    spi_word(8'hC3, mi2);
    cyc(HALF);
    cs = 1'b1;
    cyc(10);
    chk("b2b_vld", vld_hi - v0, 2);
    chk("b2b_miso0", mi, 8'h81);
    chk("b2b_miso1", mi2, 8'h7E);
    chk("b2b_qlen", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", rx_q[0], 8'h5A);
      chk("b2b_rx1", rx_q[1], 8'hC3);
    end

    // Deselected noise.
    v0 = vld_hi;
    mosi = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(HALF); sclk = 1'b1;
      cyc(HALF); sclk = 1'b0;
    end
    cyc(10);
    chk("noise_vld", vld_hi - v0, 0);
    chk("noise_busy", busy, 0);
    chk("noise_miso", miso, 0);
    chk("noise_rx", rx_data, 8'h7E ^ 8'h7E ^ 8'hC3);

    // Reset mid-frame after 3 bits, clock halted so the check is purely asynchronous.
    tx_data = 8'hFF;
    cyc(2);
    cs = 1'b0;
    cyc(HALF);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
    cyc(HALF);
    chk("mid_busy_pre", busy, 1);
    chk("mid_miso_pre", miso, 1);
    clk_en = 1'b0;
    #12 rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", miso, 0);
    chk("mid_rst_rx_data", rx_data, 0);
    chk("mid_rst_rx_valid", rx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    clk_en = 1'b1;
    cyc(3);
    @(negedge clk) rst_n = 1'b1;
    cyc(10);
    chk("mid_idle_cs_low", busy, 0);
    cs = 1'b1;
    cyc(10);
    v0 = vld_hi;
    frame(8'h99, mi);
    chk("mid_rx", rx_data, 8'h99);
    chk("mid_vld", vld_hi - v0, 1);
    chk("mid_miso", mi, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
